vme_req_sequencer: RTL and testbench

Host-side request sequencer placed directly upstream of a generated VME register block. It accepts single read/write requests from a local host port, drives the block's `VMERdMem`/`VMEWrMem` strobes as one-cycle pulses with stable address/data, and waits for `VMERdDone`/`VMEWrDone`. It returns read data and an acknowledge to the host, and ends stalled accesses with an error after a programmable timeout.

---
 rtl/vme_req_sequencer.sv | 118 +++++++++++
 tb/tb_vme_req_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_req_sequencer.sv
// Host-side request sequencer for a generated VME register block: one access in flight,
// single-cycle Rd/Wr strobes, Done-based completion and a programmable stall timeout.
module vme_req_sequencer #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          rst_n,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic          host_busy,
    output logic          host_ack,
    output logic          host_err,
    output logic [31:0]   host_rdata,
    output logic [7:0]    err_count,
    output logic [AW-1:0] VMEAddr,
    output logic [31:0]   VMEWrData,
    output logic          VMERdMem,
    output logic          VMEWrMem,
    input  logic [31:0]   VMERdData,
    input  logic          VMERdDone,
    input  logic          VMEWrDone
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t        state;
    logic          op_we;
    logic [CW-1:0] cnt;
    logic          done_match;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only the Done that matches the latched access type counts.
    always_comb begin
        done_match = op_we ? VMEWrDone : VMERdDone;
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            cnt        <= '0;
            host_busy  <= 1'b0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= 32'h0;
            err_count  <= 8'h0;
            VMEAddr    <= '0;
            VMEWrData  <= 32'h0;
            VMERdMem   <= 1'b0;
            VMEWrMem   <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            host_err <= 1'b0;
            VMERdMem <= 1'b0;
            VMEWrMem <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high during the ack cycle, so a request there is ignored.
                    if (!host_busy && host_req) begin
                        op_we     <= host_we;
                        VMEAddr   <= host_addr;
                        VMEWrData <= host_wdata;
                        VMERdMem  <= ~host_we;
                        VMEWrMem  <= host_we;
                        cnt       <= '0;
                        host_busy <= 1'b1;
                        state     <= STROBE;
                    end else begin
                        host_busy <= 1'b0;
                    end
                end
                STROBE: begin
                    if (done_match) begin
                        state    <= IDLE;
                        host_ack <= 1'b1;
                        if (!op_we) host_rdata <= VMERdData;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A Done in the final counted cycle still wins over the timeout.
                    if (done_match) begin
                        state    <= IDLE;
                        host_ack <= 1'b1;
                        if (!op_we) host_rdata <= VMERdData;
                    end else if (cnt == CNT_LAST) begin
                        state      <= IDLE;
                        host_ack   <= 1'b1;
                        host_err   <= 1'b1;
                        host_rdata <= 32'h0;
                        err_count  <= sat_inc8(err_count);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    host_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vme_req_sequencer.sv
// Scoreboard bench for vme_req_sequencer: a small register-model slave with programmable
// Done latency/injection, expected completions queued at request time and checked on ack.
module tb_vme_req_sequencer;

    localparam int AW = 16;
    localparam int T  = 4;

    logic          Clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [31:0]   host_wdata = 32'h0;
    logic          host_busy, host_ack, host_err;
    logic [31:0]   host_rdata;
    logic [7:0]    err_count;
    logic [AW-1:0] VMEAddr;
    logic [31:0]   VMEWrData;
    logic          VMERdMem, VMEWrMem;
    logic [31:0]   VMERdData = 32'h0;
    logic          VMERdDone = 1'b0;
    logic          VMEWrDone = 1'b0;

    vme_req_sequencer #(.AW(AW), .TIMEOUT(T)) dut (
        .Clk(Clk), .rst_n(rst_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_busy(host_busy), .host_ack(host_ack), .host_err(host_err),
        .host_rdata(host_rdata), .err_count(err_count),
        .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
        .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int            s;
        int            ack;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          err;
        logic [31:0]   rdata;
    } exp_t;

    exp_t sb[$];

    // Slave: register model with per-type Done latency, or silent with injected Done offsets.
    bit          silent = 1'b0;
    int          rd_lat = 1;
    int          wr_lat = 2;
    int          inj_wr_off = -1;
    int          inj_rd_off = -1;
    int          wr_at = -1;
    int          rd_at = -1;
    logic [31:0] mem [16] = '{default: 32'h0};

    always @(negedge Clk) begin
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
        VMERdData = 32'hDEAD_0000 | 32'(cyc & 16'hFFFF);
        if (VMERdMem || VMEWrMem) begin
            if (VMEWrMem) mem[VMEAddr[3:0]] = VMEWrData;
            if (!silent) begin
                if (VMEWrMem) wr_at = cyc + wr_lat;
                else          rd_at = cyc + rd_lat;
            end
            if (inj_wr_off >= 0) wr_at = cyc + inj_wr_off;
            if (inj_rd_off >= 0) rd_at = cyc + inj_rd_off;
        end
        if (cyc == wr_at) begin
            VMEWrDone = 1'b1;
            wr_at = -1;
        end
        if (cyc == rd_at) begin
            VMERdDone = 1'b1;
            VMERdData = mem[VMEAddr[3:0]];
            rd_at = -1;
        end
    end

    // Monitor: strobe shape, completion timing and result against the queued expectation.
    int          n_strb = 0;
    int          n_ack = 0;
    int          exp_ec = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        prev_strb = 1'b0;
    exp_t        me;

    always @(negedge Clk) begin
        if (!host_ack) check("err_without_ack", host_err, 1'b0);
        if (VMERdMem || VMEWrMem) begin
            n_strb++;
            check("strb_both", VMERdMem & VMEWrMem, 1'b0);
            check("strb_len", prev_strb, 1'b0);
            if (sb.size() == 0) check("strb_unexpected", 1, 0);
            else begin
                check("strb_cyc", cyc, sb[0].s);
                check("strb_we", VMEWrMem, sb[0].we);
                check("strb_addr", VMEAddr, sb[0].addr);
                if (sb[0].we) check("strb_wdata", VMEWrData, sb[0].wdata);
            end
        end
        prev_strb = VMERdMem | VMEWrMem;
        if (host_ack) begin
            n_ack++;
            check("busy_in_ack", host_busy, 1'b1);
            if (sb.size() == 0) check("ack_unexpected", 1, 0);
            else begin
                me = sb.pop_front();
                if (me.err) begin
                    exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
                    last_rdata = 32'h0;
                end else if (!me.we) begin
                    last_rdata = me.rdata;
                end
                check("ack_cyc", cyc, me.ack);
                check("ack_err", host_err, me.err);
                check("ack_rdata", host_rdata, last_rdata);
                check("err_count", err_count, exp_ec);
                check("addr_hold", VMEAddr, me.addr);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (host_busy && n < 50) begin
            @(negedge Clk);
            n++;
        end
        ok = !host_busy;
        if (!ok) check("ready_timeout", host_busy, 1'b0);
    endtask

    // k = Done latency after the strobe; negative means the access is expected to time out.
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input int k, input logic [31:0] rdata);
        exp_t e;
        bit   ok;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        host_req   = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            host_req = 1'b0;
            return;
        end
        e.s     = cyc + 1;
        e.ack   = (k < 0) ? cyc + 2 + T : cyc + 2 + k;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = (k < 0);
        e.rdata = rdata;
        sb.push_back(e);
        @(negedge Clk);
        host_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   b_strb, b_ack;
        exp_t e;

        repeat (3) @(negedge Clk);
        check("rst_busy", host_busy, 1'b0);
        check("rst_ack", host_ack, 1'b0);
        check("rst_err", host_err, 1'b0);
        check("rst_rdata", host_rdata, 32'h0);
        check("rst_err_count", err_count, 8'h0);
        check("rst_addr", VMEAddr, 16'h0);
        check("rst_wrdata", VMEWrData, 32'h0);
        check("rst_rdmem", VMERdMem, 1'b0);
        check("rst_wrmem", VMEWrMem, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        check("idle_busy", host_busy, 1'b0);
        check("idle_ack", host_ack, 1'b0);

        // Reset asserted asynchronously in the strobe cycle of a read.
        silent    = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'h0003;
        host_req  = 1'b1;
        wait_ready(ok);
        @(posedge Clk);
        #1;
        host_req = 1'b0;
        check("arst_strobe_before", VMERdMem, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rdmem", VMERdMem, 1'b0);
        check("arst_busy", host_busy, 1'b0);
        @(negedge Clk);
        rst_n = 1'b1;
        b_ack = n_ack;
        repeat (10) @(negedge Clk);
        check("arst_no_ack", n_ack - b_ack, 0);
        silent = 1'b0;

        // Register-model write then read back.
        do_req(1'b1, 16'h0000, 32'h0000_00A5, 2, 32'h0);
        drain();
        do_req(1'b0, 16'h0000, 32'h0, 1, 32'h0000_00A5);
        drain();

        // Zero-latency slave.
        rd_lat = 0;
        wr_lat = 0;
        do_req(1'b1, 16'h0005, 32'h1234_5678, 0, 32'h0);
        do_req(1'b0, 16'h0005, 32'h0, 0, 32'h1234_5678);
        drain();
        rd_lat = 1;
        wr_lat = 2;

        // Non-matching Done must be ignored.
        silent     = 1'b1;
        inj_wr_off = 0;
        inj_rd_off = 3;
        do_req(1'b0, 16'h0005, 32'h0, 3, 32'h1234_5678);
        drain();
        inj_wr_off = 2;
        inj_rd_off = 0;
        do_req(1'b1, 16'h0006, 32'h0000_CAFE, 2, 32'h0);
        drain();
        inj_wr_off = -1;
        inj_rd_off = -1;

        // Timeouts with a silent slave, until err_count saturates.
        do_req(1'b0, 16'h0007, 32'h0, -1, 32'h0);
        drain();
        check("err_count_first", err_count, 8'd1);
        for (int i = 1; i < 300; i++) do_req(i[0], 16'h0007, 32'(i), -1, 32'h0);
        drain();
        check("err_count_sat", err_count, 8'd255);
        silent = 1'b0;

        // Normal traffic after timeouts: read data recovers, then a write leaves it held.
        do_req(1'b0, 16'h0006, 32'h0, 1, 32'h0000_CAFE);
        do_req(1'b1, 16'h0002, 32'h5A5A_0002, 2, 32'h0);
        drain();

        // Back-to-back with host_req held high across four writes.
        b_strb     = n_strb;
        b_ack      = n_ack;
        host_we    = 1'b1;
        host_addr  = 16'h0008;
        host_wdata = 32'h0000_0100;
        host_req   = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ready(ok);
            if (!ok) break;
            e.s     = cyc + 1;
            e.ack   = cyc + 2 + wr_lat;
            e.we    = 1'b1;
            e.addr  = host_addr;
            e.wdata = host_wdata;
            e.err   = 1'b0;
            e.rdata = 32'h0;
            sb.push_back(e);
            @(negedge Clk);
            if (n < 3) begin
                host_addr  = 16'(9 + n);
                host_wdata = 32'h0000_0101 + 32'(n);
            end else begin
                host_req = 1'b0;
            end
        end
        host_req = 1'b0;
        drain();
        repeat (5) @(negedge Clk);
        check("b2b_strobes", n_strb - b_strb, 4);
        check("b2b_acks", n_ack - b_ack, 4);
        check("b2b_mem_last", mem[11], 32'h0000_0103);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
